rsa_modexp_unit: RTL

//  Bit-serial RSA core: computes cipher = plain^exp mod modulus (right-to-left square-and-multiply).

---
 rtl/rsa_modexp_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rsa_modexp_unit.sv
// Purpose : bit-serial RSA core, cipher = plain^exp mod modulus (right-to-left square-and-multiply)
// Latency : 1 + WIDTH + 2*WIDTH^2 step cycles to eoc (constant time); err case 1 step cycle
// Backpr. : none; ena & en_rsa gate every register, deasserting either freezes the unit in place
//
// Ports: clk, rstb (sync, active-low), ena/en_rsa (step enables), rst_rsa (soft clear, active-low,
//   captures plain/exp/modulus), cipher (registered result), eoc_rsa_unit (level), busy, err (modulus<2).
// Option: RSA_EARLY_EXIT_EN selects variable-time mode (skips MUL for zero exponent bits and stops
//   after the top set bit); results are identical in both modes.
module rsa_modexp_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             en_rsa,
  input  logic             rst_rsa,
  input  logic [WIDTH-1:0] plain,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] cipher,
  output logic             eoc_rsa_unit,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_MUL, S_SQR, S_DONE} state_t;

  state_t           state_q, nxt_state;
  logic [WIDTH-1:0] mr_q, er_q, nr_q, res_q, base_q, a_q, cipher_q;
  logic [WIDTH:0]   acc_q;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    bitcnt_q;
  logic             eoc_q, busy_q, err_q;

  logic             step, last;
  logic [WIDTH-1:0] mm_b, mm_out, res_d, base_d, er_d;
  logic [WIDTH:0]   n_ext, dbl, red1, add, acc_d;

  assign step = ena & en_rsa;

  // One interleaved-multiplier step: acc = (2*acc + a_bit*B) mod N, two conditional subtracts.
  // acc < N < 2^WIDTH, so 2*acc and red1 + B both fit in WIDTH+1 bits.
  always_comb begin
    mm_b   = (state_q == S_INIT) ? WIDTH'(1) : base_q;
    n_ext  = {1'b0, nr_q};
    dbl    = acc_q << 1;
    red1   = (dbl >= n_ext) ? dbl - n_ext : dbl;
    add    = red1 + (a_q[WIDTH-1] ? {1'b0, mm_b} : '0);
    acc_d  = (add >= n_ext) ? add - n_ext : add;
    mm_out = acc_d[WIDTH-1:0];
    last   = (cnt_q == CW'(WIDTH - 1));
    res_d  = (state_q == S_MUL && last && er_q[0]) ? mm_out : res_q;
    base_d = ((state_q == S_INIT || state_q == S_SQR) && last) ? mm_out : base_q;
    er_d   = (state_q == S_SQR && last) ? (er_q >> 1) : er_q;
  end

  // Successor of a finished multiply phase.
  always_comb begin
    nxt_state = S_DONE;
    case (state_q)
`ifdef RSA_EARLY_EXIT_EN
      // A zero exponent bit skips MUL; once no set bits remain the trailing SQRs are pointless.
      S_INIT, S_SQR: begin
        if (er_d == '0 || (state_q == S_SQR && bitcnt_q == BW'(WIDTH - 1))) nxt_state = S_DONE;
        else if (er_d[0])                                                 nxt_state = S_MUL;
        else                                                              nxt_state = S_SQR;
      end
      S_MUL:  nxt_state = (er_q[WIDTH-1:1] == '0) ? S_DONE : S_SQR;
`else
      S_INIT: nxt_state = S_MUL;
      S_MUL:  nxt_state = S_SQR;
      S_SQR:  nxt_state = (bitcnt_q == BW'(WIDTH - 1)) ? S_DONE : S_MUL;
`endif
      default: nxt_state = S_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q  <= S_IDLE;
      mr_q     <= '0;
      er_q     <= '0;
      nr_q     <= '0;
      res_q    <= '0;
      base_q   <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      cipher_q <= '0;
      eoc_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (step) begin
      if (!rst_rsa) begin
        state_q <= S_IDLE;
        mr_q    <= plain;
        er_q    <= exp;
        nr_q    <= modulus;
        eoc_q   <= 1'b0;
        err_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (nr_q < WIDTH'(2)) begin
              err_q    <= 1'b1;
              cipher_q <= '0;
              eoc_q    <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              res_q    <= WIDTH'(1);
              bitcnt_q <= '0;
              acc_q    <= '0;
              cnt_q    <= '0;
              a_q      <= mr_q;   // INIT computes M*1 mod N, reducing M >= N
              busy_q   <= 1'b1;
              state_q  <= S_INIT;
            end
          end
          S_INIT, S_MUL, S_SQR: begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_q + CW'(1);
            a_q    <= a_q << 1;
            res_q  <= res_d;
            base_q <= base_d;
            er_q   <= er_d;
            if (last) begin
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= nxt_state;
              if (state_q == S_SQR) bitcnt_q <= bitcnt_q + BW'(1);
              if (nxt_state == S_DONE) begin
                cipher_q <= res_d;
                eoc_q    <= 1'b1;
                busy_q   <= 1'b0;
              end else begin
                // Next multiplier operand uses this edge's freshly written res/base.
                a_q <= (nxt_state == S_SQR) ? base_d : res_d;
              end
            end
          end
          default: ;  // DONE holds until soft clear or reset
        endcase
      end
    end
  end

  assign cipher       = cipher_q;
  assign eoc_rsa_unit = eoc_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule
